// File: rtl/dtc_pkg.sv
// Shared types, sizing and phase-wrap helper for the DTC phase generator.
package dtc_pkg;

    localparam int DTC_NBIT = 4;
    localparam int DTC_DIV  = 32;
    localparam int CNTW     = $clog2(DTC_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // div is a power of two, so masking the two's-complement code gives code mod div.
    function automatic logic [31:0] wrap_phase(input int code, input int div);
        return 32'(code & (div - 1));
    endfunction

endpackage

// File: rtl/dtc_period_cnt.sv
// Period counter for the DTC: counts while active, held at zero when idle, flags the last cycle.
module dtc_period_cnt
    import dtc_pkg::*;
#(
    parameter int DIV = DTC_DIV,
    parameter int CW  = CNTW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          active,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          last
);

    // DIV is a power of two, so the natural CW-bit rollover is the DIV-1 -> 0 wrap.
    always_comb begin
        cnt_nxt = active ? cnt + 1'b1 : '0;
    end

    assign last = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dtc_phase_gen.sv
// DTC phase generator: reference and code-delayed feedback clocks divided from the fast clock.
// Optional slew limiting of the applied phase is enabled with DTC_SLEW_LIMIT_EN.
//
// state | meaning
// IDLE  | outputs low, counter held at 0
// RUN   | generating clocks, code_ready strobes on the last cycle of each period
// DRAIN | finishing the current period after en dropped, no codes accepted
module dtc_phase_gen
    import dtc_pkg::*;
#(
    parameter int Nbit = DTC_NBIT,
    parameter int DIV  = DTC_DIV,
    parameter int HALF = DIV / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic signed [Nbit-1:0] code_in,
    input  logic                   code_valid,
    output logic                   code_ready,
    output logic                   clk_ref_out,
    output logic                   clk_fb_out,
    output logic signed [Nbit-1:0] phase_cur
);

    localparam int CW = $clog2(DIV);

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic [CW-1:0]          p_nxt;
    logic [CW-1:0]          fb_diff;
    logic                   last;
    logic                   active;
    logic                   run_nxt;
    logic                   xfer;
    logic signed [Nbit-1:0] phase_nxt;

    assign active = (state != IDLE);
    assign xfer   = code_valid && code_ready;

    dtc_period_cnt #(
        .DIV (DIV),
        .CW  (CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .active  (active),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .last    (last)
    );

    // A stop requested on the last cycle of a period ends it immediately; no extra period is drained.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = en ? RUN : IDLE;
                end else if (!en) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last) begin
                    state_nxt = en ? RUN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DTC_SLEW_LIMIT_EN
    logic signed [Nbit-1:0] code_tgt;
    logic signed [Nbit-1:0] tgt_eff;

    always_comb begin
        tgt_eff   = xfer ? code_in : code_tgt;
        phase_nxt = phase_cur;
        if (active && last) begin
            if (tgt_eff > phase_cur) begin
                phase_nxt = phase_cur + Nbit'(1);
            end else if (tgt_eff < phase_cur) begin
                phase_nxt = phase_cur - Nbit'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_tgt <= '0;
        end else if (xfer) begin
            code_tgt <= code_in;
        end
    end
`else
    always_comb begin
        phase_nxt = phase_cur;
        if (xfer) begin
            phase_nxt = code_in;
        end
    end
`endif

    // Outputs are computed from next-cycle state so they line up with state/cnt and stay glitch-free.
    always_comb begin
        run_nxt = (state_nxt != IDLE);
        p_nxt   = CW'(wrap_phase(int'(phase_nxt), DIV));
        fb_diff = cnt_nxt - p_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase_cur   <= '0;
            clk_ref_out <= 1'b0;
            clk_fb_out  <= 1'b0;
            code_ready  <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase_cur   <= phase_nxt;
            clk_ref_out <= run_nxt && (cnt_nxt < CW'(HALF));
            clk_fb_out  <= run_nxt && (fb_diff < CW'(HALF));
            code_ready  <= (state_nxt == RUN) && (cnt_nxt == CW'(DIV - 1));
        end
    end

endmodule
